// File: rtl/data_delay_pkg.sv
// Shared definitions for the data_delay / tap_serializer pair: default sizes,
// index width derivation, serializer states and the tap slicing convention.
package data_delay_pkg;

    localparam int DEFAULT_BITS  = 16;
    localparam int DEFAULT_DELAY = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int idx_width(input int delay);
        return $clog2(delay);
    endfunction

    // Tap k of a frame lives at bits [k*BITS +: BITS]; tap 0 is the newest sample.
    function automatic int tap_lsb(input int k, input int bits);
        return k * bits;
    endfunction

endpackage

// File: rtl/tap_serializer_if.sv
// Frame-in / word-out handshake bundle between a tap_serializer and its neighbours.
interface tap_serializer_if
    import data_delay_pkg::*;
#(
    parameter int BITS  = DEFAULT_BITS,
    parameter int DELAY = DEFAULT_DELAY
);

    logic [DELAY*BITS-1:0] i_Din;
    logic                  i_valid;
    logic                  o_ready;
    logic [BITS-1:0]       o_Dout;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_last;
    logic                  o_busy;

    modport master (
        output i_Din, i_valid, i_ready,
        input  o_ready, o_Dout, o_valid, o_last, o_busy
    );

    modport slave (
        input  i_Din, i_valid, i_ready,
        output o_ready, o_Dout, o_valid, o_last, o_busy
    );

endinterface

// File: rtl/tap_index_counter.sv
// Loadable up/down tap index that saturates at the final tap of its direction
// and flags when it sits there.
module tap_index_counter
    import data_delay_pkg::*;
#(
    parameter int DELAY = DEFAULT_DELAY,
    parameter int IDX_W = idx_width(DEFAULT_DELAY)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             load,
    input  logic [IDX_W-1:0] load_val,
    input  logic             down,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             at_final
);

    localparam logic [IDX_W-1:0] TOP_TAP = IDX_W'(DELAY - 1);

    assign at_final = down ? (idx == '0) : (idx == TOP_TAP);

    // Holding at the final tap keeps idx inside [0, DELAY-1] with no wrap.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            idx <= '0;
        end else if (load) begin
            idx <= load_val;
        end else if (en && !at_final) begin
            idx <= down ? (idx - 1'b1) : (idx + 1'b1);
        end
    end

endmodule

// File: rtl/tap_serializer.sv
// Captures one DELAY-tap frame and replays it word by word over a valid/ready
// stream, oldest or newest tap first.
module tap_serializer
    import data_delay_pkg::*;
#(
    parameter int BITS         = DEFAULT_BITS,
    parameter int DELAY        = DEFAULT_DELAY,
    parameter int OLDEST_FIRST = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    tap_serializer_if.slave bus
);

    localparam int               IDX_W     = idx_width(DELAY);
    localparam logic [IDX_W-1:0] FIRST_TAP = (OLDEST_FIRST != 0) ? IDX_W'(DELAY - 1) : '0;

    state_t                      state, state_n;
    logic                        ready_q, ready_n;
    logic [DELAY-1:0][BITS-1:0]  frame_q;
    logic [IDX_W-1:0]            idx;
    logic                        at_final;
    logic                        accept;
    logic                        xfer;
    logic                        cnt_down;

    assign cnt_down = (OLDEST_FIRST != 0);

    tap_index_counter #(
        .DELAY (DELAY),
        .IDX_W (IDX_W)
    ) u_idx (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load     (accept),
        .load_val (FIRST_TAP),
        .down     (cnt_down),
        .en       (xfer),
        .idx      (idx),
        .at_final (at_final)
    );

    // o_ready is registered, so it only rises on the first edge after reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            frame_q <= '0;
        end else begin
            state   <= state_n;
            ready_q <= ready_n;
            if (accept) begin
                for (int k = 0; k < DELAY; k++) begin
                    frame_q[k] <= bus.i_Din[tap_lsb(k, BITS) +: BITS];
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        ready_n = ready_q;
        accept  = 1'b0;
        xfer    = 1'b0;
        case (state)
            IDLE: begin
                accept  = bus.i_valid && ready_q;
                ready_n = !accept;
                if (accept) begin
                    state_n = SEND;
                end
            end
            SEND: begin
                xfer    = bus.i_ready;
                ready_n = 1'b0;
                if (xfer && at_final) begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b0;
            end
        endcase
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = (state == SEND);
    assign bus.o_busy  = (state == SEND);
    assign bus.o_last  = (state == SEND) && at_final;
    assign bus.o_Dout  = (state == SEND) ? frame_q[idx] : '0;

endmodule

// File: tb/tb_tap_serializer.sv
// Directed bench for tap_serializer: both emit orders run side by side on the
// same stimulus, with hand-computed word sequences.
module tb_tap_serializer;
    import data_delay_pkg::*;

    localparam int BITS  = 16;
    localparam int DELAY = 4;

    logic i_clk;
    logic i_rst;
    int   checks;
    int   errors;

    tap_serializer_if #(.BITS(BITS), .DELAY(DELAY)) bus_of ();
    tap_serializer_if #(.BITS(BITS), .DELAY(DELAY)) bus_nf ();

    assign bus_nf.i_Din   = bus_of.i_Din;
    assign bus_nf.i_valid = bus_of.i_valid;
    assign bus_nf.i_ready = bus_of.i_ready;

    tap_serializer #(.BITS(BITS), .DELAY(DELAY), .OLDEST_FIRST(1)) dut_of (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus_of)
    );

    tap_serializer #(.BITS(BITS), .DELAY(DELAY), .OLDEST_FIRST(0)) dut_nf (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus_nf)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Inputs change only at falling edges, right after the outputs are sampled.
    task automatic test_reset();
        i_rst          = 1'b0;
        bus_of.i_Din   = {$urandom, $urandom};
        bus_of.i_valid = 1'b1;
        bus_of.i_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        if (bus_of.o_valid !== 1'b0 || bus_of.o_ready !== 1'b0 || bus_of.o_Dout !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_of: valid=%b ready=%b dout=%h expected 0 0 0000",
                     bus_of.o_valid, bus_of.o_ready, bus_of.o_Dout);
        end
        checks++;
        if (bus_nf.o_valid !== 1'b0 || bus_nf.o_ready !== 1'b0 || bus_nf.o_busy !== 1'b0 || bus_nf.o_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_nf: valid=%b ready=%b busy=%b last=%b expected 0 0 0 0",
                     bus_nf.o_valid, bus_nf.o_ready, bus_nf.o_busy, bus_nf.o_last);
        end
        checks++;
        bus_of.i_valid = 1'b0;
        i_rst          = 1'b1;
        #1;
        if (bus_of.o_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release_ready_early: got %b expected 0", bus_of.o_ready);
        end
        checks++;
        @(negedge i_clk);
        if (bus_of.o_ready !== 1'b1 || bus_nf.o_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: of=%b nf=%b expected 1 1", bus_of.o_ready, bus_nf.o_ready);
        end
        checks++;
    endtask

    task automatic test_basic();
        logic [15:0] exp_of [4];
        logic [15:0] exp_nf [4];
        exp_of = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
        exp_nf = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        bus_of.i_Din   = 64'h0004_0003_0002_0001;
        bus_of.i_valid = 1'b1;
        bus_of.i_ready = 1'b1;
        @(negedge i_clk);
        bus_of.i_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if (bus_of.o_valid !== 1'b1 || bus_of.o_Dout !== exp_of[w] || bus_of.o_last !== (w == 3)
                || bus_of.o_ready !== 1'b0 || bus_of.o_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL basic_of w%0d: valid=%b dout=%h last=%b ready=%b busy=%b expected 1 %h %b 0 1",
                         w, bus_of.o_valid, bus_of.o_Dout, bus_of.o_last, bus_of.o_ready, bus_of.o_busy,
                         exp_of[w], (w == 3));
            end
            checks++;
            if (bus_nf.o_valid !== 1'b1 || bus_nf.o_Dout !== exp_nf[w] || bus_nf.o_last !== (w == 3)) begin
                errors++;
                $display("[TB] FAIL basic_nf w%0d: valid=%b dout=%h last=%b expected 1 %h %b",
                         w, bus_nf.o_valid, bus_nf.o_Dout, bus_nf.o_last, exp_nf[w], (w == 3));
            end
            checks++;
            @(negedge i_clk);
        end
        if (bus_of.o_valid !== 1'b0 || bus_of.o_ready !== 1'b1 || bus_of.o_last !== 1'b0 || bus_nf.o_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_end: of valid=%b ready=%b last=%b nf ready=%b expected 0 1 0 1",
                     bus_of.o_valid, bus_of.o_ready, bus_of.o_last, bus_nf.o_ready);
        end
        checks++;
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_of [8];
        logic [15:0] exp_nf [8];
        logic        rdy    [8];
        exp_of = '{16'h0004, 16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
        exp_nf = '{16'h0001, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0003, 16'h0004, 16'h0000};
        rdy    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bus_of.i_Din   = 64'h0004_0003_0002_0001;
        bus_of.i_valid = 1'b1;
        bus_of.i_ready = 1'b1;
        @(negedge i_clk);
        bus_of.i_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus_of.o_valid !== (c < 7) || bus_of.o_Dout !== exp_of[c] || bus_of.o_last !== (c == 6)) begin
                errors++;
                $display("[TB] FAIL stall_of c%0d: valid=%b dout=%h last=%b expected %b %h %b",
                         c, bus_of.o_valid, bus_of.o_Dout, bus_of.o_last, (c < 7), exp_of[c], (c == 6));
            end
            checks++;
            if (bus_nf.o_valid !== (c < 7) || bus_nf.o_Dout !== exp_nf[c] || bus_nf.o_last !== (c == 6)) begin
                errors++;
                $display("[TB] FAIL stall_nf c%0d: valid=%b dout=%h last=%b expected %b %h %b",
                         c, bus_nf.o_valid, bus_nf.o_Dout, bus_nf.o_last, (c < 7), exp_nf[c], (c == 6));
            end
            checks++;
            bus_of.i_ready = rdy[c];
            @(negedge i_clk);
        end
    endtask

    task automatic test_busy_ignored();
        logic [15:0] exp_of [4];
        exp_of = '{16'h0040, 16'h0030, 16'h0020, 16'h0010};
        bus_of.i_ready = 1'b1;
        bus_of.i_Din   = 64'h0040_0030_0020_0010;
        bus_of.i_valid = 1'b1;
        @(negedge i_clk);
        bus_of.i_Din = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int w = 0; w < 4; w++) begin
            if (bus_of.o_Dout !== exp_of[w] || bus_of.o_last !== (w == 3) || bus_of.o_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_of w%0d: dout=%h last=%b ready=%b expected %h %b 0",
                         w, bus_of.o_Dout, bus_of.o_last, bus_of.o_ready, exp_of[w], (w == 3));
            end
            checks++;
            if (bus_nf.o_Dout !== exp_of[3-w]) begin
                errors++;
                $display("[TB] FAIL busy_nf w%0d: dout=%h expected %h", w, bus_nf.o_Dout, exp_of[3-w]);
            end
            checks++;
            @(negedge i_clk);
        end
        if (bus_of.o_valid !== 1'b0 || bus_of.o_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_gap: valid=%b ready=%b expected 0 1", bus_of.o_valid, bus_of.o_ready);
        end
        checks++;
        @(negedge i_clk);
        bus_of.i_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if (bus_of.o_valid !== 1'b1 || bus_of.o_Dout !== 16'hFFFF || bus_of.o_last !== (w == 3)
                || bus_nf.o_Dout !== 16'hFFFF || bus_nf.o_last !== (w == 3)) begin
                errors++;
                $display("[TB] FAIL busy_next w%0d: of valid=%b dout=%h last=%b nf dout=%h last=%b expected 1 ffff %b",
                         w, bus_of.o_valid, bus_of.o_Dout, bus_of.o_last, bus_nf.o_Dout, bus_nf.o_last, (w == 3));
            end
            checks++;
            @(negedge i_clk);
        end
        if (bus_of.o_valid !== 1'b0 || bus_of.o_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_end: valid=%b ready=%b expected 0 1", bus_of.o_valid, bus_of.o_ready);
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        bus_of.i_ready = 1'b1;
        bus_of.i_Din   = 64'h0040_0030_0020_0010;
        bus_of.i_valid = 1'b1;
        @(negedge i_clk);
        bus_of.i_valid = 1'b0;
        if (bus_of.o_Dout !== 16'h0040 || bus_nf.o_Dout !== 16'h0010) begin
            errors++;
            $display("[TB] FAIL mid_w0: of=%h nf=%h expected 0040 0010", bus_of.o_Dout, bus_nf.o_Dout);
        end
        checks++;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        if (bus_of.o_valid !== 1'b0 || bus_of.o_Dout !== 16'h0000 || bus_of.o_last !== 1'b0
            || bus_of.o_busy !== 1'b0 || bus_of.o_ready !== 1'b0 || bus_nf.o_Dout !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL mid_reset: valid=%b dout=%h last=%b busy=%b ready=%b nf dout=%h expected 0 0000 0 0 0 0000",
                     bus_of.o_valid, bus_of.o_Dout, bus_of.o_last, bus_of.o_busy, bus_of.o_ready, bus_nf.o_Dout);
        end
        checks++;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        if (bus_of.o_ready !== 1'b1 || bus_of.o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_release: ready=%b valid=%b expected 1 0", bus_of.o_ready, bus_of.o_valid);
        end
        checks++;
        bus_of.i_Din   = 64'h00AA_00AA_00AA_00AA;
        bus_of.i_valid = 1'b1;
        @(negedge i_clk);
        bus_of.i_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if (bus_of.o_valid !== 1'b1 || bus_of.o_Dout !== 16'h00AA || bus_of.o_last !== (w == 3)
                || bus_nf.o_Dout !== 16'h00AA || bus_nf.o_last !== (w == 3)) begin
                errors++;
                $display("[TB] FAIL mid_new w%0d: of valid=%b dout=%h last=%b nf dout=%h last=%b expected 1 00aa %b",
                         w, bus_of.o_valid, bus_of.o_Dout, bus_of.o_last, bus_nf.o_Dout, bus_nf.o_last, (w == 3));
            end
            checks++;
            @(negedge i_clk);
        end
        if (bus_of.o_valid !== 1'b0 || bus_of.o_ready !== 1'b1 || bus_nf.o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_end: of valid=%b ready=%b nf valid=%b expected 0 1 0",
                     bus_of.o_valid, bus_of.o_ready, bus_nf.o_valid);
        end
        checks++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_ignored();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
